// File: rtl/frv_asi_issue.sv
// Requester side of the ASI handshake: registers one decoded op, presents it
// to the ASI unit, buffers the result for writeback and owns the AES flush.
module frv_asi_issue #(
    parameter int          XLEN      = 32,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] LFSR_SEED = 32'h6A09E667,
    parameter int          OP        = 6
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [OP:0]     s_uop,
    input  logic [XLEN-1:0] s_rs1,
    input  logic [XLEN-1:0] s_rs2,
    input  logic [1:0]      s_shamt,
    input  logic [4:0]      s_rd,
    input  logic            kill,
    output logic            asi_valid,
    input  logic            asi_ready,
    output logic [OP:0]     asi_uop,
    output logic [XLEN-1:0] asi_rs1,
    output logic [XLEN-1:0] asi_rs2,
    output logic [1:0]      asi_shamt,
    input  logic [XLEN-1:0] asi_result,
    output logic            asi_flush_aessub,
    output logic            asi_flush_aesmix,
    output logic [31:0]     asi_flush_data,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_result,
    output logic [4:0]      wb_rd,
    output logic            wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]  SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam int           CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Galois step, polynomial x^32+x^22+x^2+x+1.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] v);
        logic [31:0] nxt;
        nxt = v >> 1;
        if (v[0]) begin
            nxt = nxt ^ 32'h80200003;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_lfsr;
    logic            r_flush;
    logic [OP:0]     r_uop;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [1:0]      r_shamt;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wb_result;
    logic            r_wb_err;
    logic            w_accept;
    logic            w_timeout;
    logic            w_flush_set;

    assign s_ready          = !kill && ((r_state == IDLE) || ((r_state == DONE) && wb_ready));
    assign w_accept         = s_valid && s_ready;
    assign w_timeout        = (r_state == BUSY) && !asi_ready && (r_cnt == CNT_LAST);
    assign asi_valid        = (r_state == BUSY);
    assign wb_valid         = (r_state == DONE);
    assign asi_uop          = r_uop;
    assign asi_rs1          = r_rs1;
    assign asi_rs2          = r_rs2;
    assign asi_shamt        = r_shamt;
    assign wb_result        = r_wb_result;
    assign wb_rd            = r_rd;
    assign wb_err           = r_wb_err;
    assign asi_flush_aessub = r_flush;
    assign asi_flush_aesmix = r_flush;
    assign asi_flush_data   = r_lfsr;

    // Next-state and flush request; kill overrides everything, including a timeout.
    always_comb begin
        w_next      = r_state;
        w_flush_set = 1'b0;
        if (kill) begin
            w_next      = IDLE;
            w_flush_set = (r_state != IDLE);
        end else begin
            w_flush_set = w_timeout;
            case (r_state)
                IDLE: begin
                    if (s_valid) w_next = BUSY;
                    else         w_next = IDLE;
                end
                BUSY: begin
                    if (asi_ready || w_timeout) w_next = DONE;
                    else                        w_next = BUSY;
                end
                DONE: begin
                    if (wb_ready) w_next = s_valid ? BUSY : IDLE;
                    else          w_next = DONE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // State, operand, result and flush-LFSR registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_lfsr      <= SEED_EFF;
            r_flush     <= 1'b0;
            r_uop       <= {(OP+1){1'b0}};
            r_rs1       <= {XLEN{1'b0}};
            r_rs2       <= {XLEN{1'b0}};
            r_shamt     <= 2'b00;
            r_rd        <= 5'd0;
            r_wb_result <= {XLEN{1'b0}};
            r_wb_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_flush <= w_flush_set;
            if (r_flush) begin
                r_lfsr <= f_lfsr_step(r_lfsr);
            end
            if (w_accept) begin
                r_uop   <= s_uop;
                r_rs1   <= s_rs1;
                r_rs2   <= s_rs2;
                r_shamt <= s_shamt;
                r_rd    <= s_rd;
                r_cnt   <= {CW{1'b0}};
            end else if ((r_state == BUSY) && !asi_ready) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            // Result capture; a timeout reports zero with the error flag.
            if (kill) begin
                r_wb_err <= 1'b0;
            end else if ((r_state == BUSY) && asi_ready) begin
                r_wb_result <= asi_result;
                r_wb_err    <= 1'b0;
            end else if (w_timeout) begin
                r_wb_result <= {XLEN{1'b0}};
                r_wb_err    <= 1'b1;
            end else if ((r_state == DONE) && wb_ready) begin
                r_wb_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frv_asi_issue.sv
// Directed self-checking bench for frv_asi_issue.
module tb_frv_asi_issue;

    localparam logic [6:0]  UOP_SHA256_S0  = 7'h24;
    localparam logic [6:0]  UOP_AESSUB_ENC = 7'h10;
    localparam logic [31:0] SEED   = 32'h6A09E667;
    localparam logic [31:0] SEED_1 = 32'hB524F330;
    localparam logic [31:0] SEED_2 = 32'h5A927998;
    localparam logic [31:0] SEED_3 = 32'h2D493CCC;

    logic        g_clk = 1'b0;
    logic        g_resetn, s_valid, s_ready, kill, asi_valid, asi_ready;
    logic [6:0]  s_uop, asi_uop;
    logic [31:0] s_rs1, s_rs2, asi_rs1, asi_rs2, asi_result, asi_flush_data, wb_result;
    logic [1:0]  s_shamt, asi_shamt;
    logic [4:0]  s_rd, wb_rd;
    logic        asi_flush_aessub, asi_flush_aesmix, wb_valid, wb_ready, wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 g_clk = ~g_clk;

    frv_asi_issue dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_uop(s_uop), .s_rs1(s_rs1), .s_rs2(s_rs2), .s_shamt(s_shamt), .s_rd(s_rd),
        .kill(kill), .asi_valid(asi_valid), .asi_ready(asi_ready), .asi_uop(asi_uop),
        .asi_rs1(asi_rs1), .asi_rs2(asi_rs2), .asi_shamt(asi_shamt),
        .asi_result(asi_result), .asi_flush_aessub(asi_flush_aessub),
        .asi_flush_aesmix(asi_flush_aesmix), .asi_flush_data(asi_flush_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_rd(wb_rd), .wb_err(wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn = 1'b0; s_valid = 1'b0; s_uop = 7'd0; s_rs1 = 32'd0; s_rs2 = 32'd0;
        s_shamt = 2'd0; s_rd = 5'd0; kill = 1'b0; asi_ready = 1'b0;
        asi_result = 32'd0; wb_ready = 1'b0;
        tick(); tick();
        chk("rst_asi_valid", 32'(asi_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        chk("rst_flush", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd0);
        chk("rst_flush_data", asi_flush_data, SEED);
        chk("rst_asi_rs1", asi_rs1, 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        g_resetn = 1'b1;

        // 1: combinational asi_ready, minimum latency
        s_valid = 1'b1; s_uop = UOP_SHA256_S0; s_rs1 = 32'h61626364; s_rd = 5'd7;
        tick();
        s_valid = 1'b0;
        chk("t1_asi_valid", 32'(asi_valid), 32'd1);
        chk("t1_asi_uop", 32'(asi_uop), 32'(UOP_SHA256_S0));
        chk("t1_asi_rs1", asi_rs1, 32'h61626364);
        chk("t1_wb_valid_early", 32'(wb_valid), 32'd0);
        asi_ready = 1'b1; asi_result = 32'hDEADBEEF;
        tick();
        asi_ready = 1'b0;
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_asi_valid_drop", 32'(asi_valid), 32'd0);
        chk("t1_wb_result", wb_result, 32'hDEADBEEF);
        chk("t1_wb_rd", 32'(wb_rd), 32'd7);
        chk("t1_wb_err", 32'(wb_err), 32'd0);
        chk("t1_s_ready_hold", 32'(s_ready), 32'd0);
        wb_ready = 1'b1;
        #1;
        chk("t1_s_ready_wb", 32'(s_ready), 32'd1);
        tick();
        wb_ready = 1'b0;
        chk("t1_idle_wb_valid", 32'(wb_valid), 32'd0);

        // 2: four-cycle ASI latency, operands held
        s_valid = 1'b1; s_uop = UOP_AESSUB_ENC; s_rs1 = 32'h11223344; s_rs2 = 32'h55667788;
        s_rd = 5'd3;
        tick();
        s_valid = 1'b0; s_rs1 = 32'hFFFFFFFF; s_rs2 = 32'h0; s_uop = 7'h7F;
        for (int i = 0; i < 4; i++) begin
            chk("t2_asi_valid", 32'(asi_valid), 32'd1);
            chk("t2_asi_uop", 32'(asi_uop), 32'(UOP_AESSUB_ENC));
            chk("t2_asi_rs1", asi_rs1, 32'h11223344);
            chk("t2_asi_rs2", asi_rs2, 32'h55667788);
            chk("t2_wb_valid_early", 32'(wb_valid), 32'd0);
            if (i == 3) begin
                asi_ready = 1'b1; asi_result = 32'hCAFEF00D;
            end
            tick();
        end
        asi_ready = 1'b0;
        chk("t2_wb_valid", 32'(wb_valid), 32'd1);
        chk("t2_wb_result", wb_result, 32'hCAFEF00D);
        chk("t2_wb_rd", 32'(wb_rd), 32'd3);

        // 3: writeback stall, then back-to-back accept
        s_valid = 1'b1; s_uop = UOP_SHA256_S0; s_rs1 = 32'h0A0B0C0D; s_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            chk("t3_wb_result", wb_result, 32'hCAFEF00D);
            chk("t3_s_ready", 32'(s_ready), 32'd0);
            chk("t3_wb_valid", 32'(wb_valid), 32'd1);
            tick();
        end
        wb_ready = 1'b1;
        #1;
        chk("t3_s_ready_b2b", 32'(s_ready), 32'd1);
        tick();
        wb_ready = 1'b0; s_valid = 1'b0;
        chk("t3_asi_valid", 32'(asi_valid), 32'd1);
        chk("t3_asi_rs1", asi_rs1, 32'h0A0B0C0D);
        chk("t3_wb_valid", 32'(wb_valid), 32'd0);

        // 4: kill in BUSY, twice; kill in IDLE is a no-op
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("t4_asi_valid", 32'(asi_valid), 32'd0);
        chk("t4_wb_valid", 32'(wb_valid), 32'd0);
        chk("t4_flush", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd3);
        chk("t4_flush_data", asi_flush_data, SEED);
        tick();
        chk("t4_flush_end", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd0);
        chk("t4_lfsr_step", asi_flush_data, SEED_1);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0; kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("t4_k2_flush", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd3);
        chk("t4_k2_flush_data", asi_flush_data, SEED_1);
        chk("t4_k2_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        chk("t4_k2_flush_end", 32'(asi_flush_aessub), 32'd0);
        chk("t4_k2_lfsr", asi_flush_data, SEED_2);
        kill = 1'b1; s_valid = 1'b1;
        #1;
        chk("t4_kill_s_ready", 32'(s_ready), 32'd0);
        tick();
        kill = 1'b0; s_valid = 1'b0;
        chk("t4_idle_kill_asi", 32'(asi_valid), 32'd0);
        chk("t4_idle_kill_flush", 32'(asi_flush_aessub), 32'd0);

        // 5: timeout after 16 BUSY cycles
        s_valid = 1'b1; s_rd = 5'd12;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t5_busy", 32'({asi_valid, wb_valid}), 32'd2);
        end
        tick();
        chk("t5_wb_valid", 32'(wb_valid), 32'd1);
        chk("t5_wb_err", 32'(wb_err), 32'd1);
        chk("t5_wb_result", wb_result, 32'd0);
        chk("t5_flush", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd3);
        chk("t5_flush_data", asi_flush_data, SEED_2);
        asi_ready = 1'b1; asi_result = 32'h12345678;
        tick();
        asi_ready = 1'b0;
        chk("t5_flush_end", 32'(asi_flush_aesmix), 32'd0);
        chk("t5_lfsr", asi_flush_data, SEED_3);
        chk("t5_ignore_ready", wb_result, 32'd0);
        chk("t5_err_hold", 32'(wb_err), 32'd1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("t5_err_clr", 32'({wb_err, wb_valid}), 32'd0);

        // 6: reset while in DONE
        s_valid = 1'b1; s_rs1 = 32'h87654321;
        tick();
        s_valid = 1'b0; asi_ready = 1'b1; asi_result = 32'h0BADF00D;
        tick();
        asi_ready = 1'b0;
        chk("t6_done", 32'(wb_valid), 32'd1);
        g_resetn = 1'b0;
        tick();
        chk("t6_asi_valid", 32'(asi_valid), 32'd0);
        chk("t6_wb_valid", 32'(wb_valid), 32'd0);
        chk("t6_wb_err", 32'(wb_err), 32'd0);
        chk("t6_flush", 32'({asi_flush_aessub, asi_flush_aesmix}), 32'd0);
        chk("t6_wb_result", wb_result, 32'd0);
        chk("t6_wb_rd", 32'(wb_rd), 32'd0);
        chk("t6_asi_rs1", asi_rs1, 32'd0);
        chk("t6_s_ready", 32'(s_ready), 32'd1);
        chk("t6_lfsr", asi_flush_data, SEED);
        g_resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
